// File: rtl/key_sched_store.sv
// key_sched_store: round-key schedule store.
//
// Holds up to NR_MAX+1 round keys of DATA_W bits. Each entry has a valid bit.
// A schedule is started with clr_i, which also latches the round count from
// mode_i. Keys are then written in order through wr_en_i. keys_ready_o rises
// once entry nr_o has been written. Reads have one cycle of latency. They can
// run in forward order or in reverse (decrypt) order.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   clr_i, mode_i   start a new schedule; mode 0/1/2/3 -> 10/12/14/10 rounds
//   wr_en_i         sequential write strobe, data taken from wr_data_i
//   wr_data_i       key written at wr_ptr_o
//   rd_en_i         read request for round rd_addr_i
//   rd_addr_i       round index to read
//   rd_rev_i        read in reverse order: effective index = nr - rd_addr
//   rd_data_o       registered read data
//   rd_valid_o      one-cycle read-hit pulse
//   rd_miss_o       one-cycle read-miss pulse
//   wr_ptr_o        next write index
//   nr_o            latched round count
//   keys_ready_o    high once entries 0..nr are all written
//   wr_err_o        sticky flag: a write was attempted while keys_ready_o was high
//   last_key_o      copy of entry nr while keys_ready_o is high, else 0
module key_sched_store #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned NR_MAX = 14,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [1:0]        mode_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic              rd_rev_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_miss_o,
    output logic [AW-1:0]     wr_ptr_o,
    output logic [AW-1:0]     nr_o,
    output logic              keys_ready_o,
    output logic              wr_err_o,
    output logic [DATA_W-1:0] last_key_o
);

    localparam int unsigned   Depth   = NR_MAX + 1;
    localparam logic [AW-1:0] LastIdx = AW'(NR_MAX);
    localparam logic [AW-1:0] Nr10    = AW'(10);
    localparam logic [AW-1:0] Nr12    = AW'(12);
    localparam logic [AW-1:0] Nr14    = AW'(14);

    // Storage, deliberately left without a reset
    logic [DATA_W-1:0] mem_q [Depth];

    logic [Depth-1:0]  valid_q, valid_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     nr_q, nr_d;
    logic              keys_ready_q, keys_ready_d;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] last_key_q, last_key_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_miss_q, rd_miss_d;

    logic [AW-1:0]     mode_nr;
    logic              wr_fire;
    logic [AW-1:0]     rd_idx;
    logic              rd_oob;
    logic              rd_hit_wr;
    logic              rd_hit_mem;

    always_comb begin
        mode_nr = Nr10;
        case (mode_i)
            2'd1:    mode_nr = Nr12;
            2'd2:    mode_nr = Nr14;
            default: mode_nr = Nr10;  // mode 3 is reserved and uses 10 rounds
        endcase
    end

    // A write takes effect only outside clr and before the schedule completes.
    // The LastIdx guard keeps the memory index in range.
    assign wr_fire = wr_en_i & ~clr_i & ~keys_ready_q & (wr_ptr_q <= LastIdx);

    // Effective read index. In reverse order, rd_addr > nr is an underflow.
    always_comb begin
        rd_idx = rd_addr_i;
        rd_oob = 1'b0;
        if (rd_rev_i) begin
            if (rd_addr_i > nr_q) begin
                rd_oob = 1'b1;
            end else begin
                rd_idx = nr_q - rd_addr_i;
            end
        end
        if ((rd_idx > nr_q) || (rd_idx > LastIdx)) begin
            rd_oob = 1'b1;
        end
    end

    // Write-first: a read that targets the entry being written returns wr_data_i
    assign rd_hit_wr  = wr_fire & ~rd_oob & (wr_ptr_q == rd_idx);
    assign rd_hit_mem = ~rd_oob & valid_q[rd_idx];

    always_comb begin
        valid_d      = valid_q;
        wr_ptr_d     = wr_ptr_q;
        nr_d         = nr_q;
        keys_ready_d = keys_ready_q;
        wr_err_d     = wr_err_q;
        last_key_d   = last_key_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        rd_miss_d    = 1'b0;

        if (clr_i) begin
            // clr overrides any write or read in the same cycle
            valid_d      = '0;
            wr_ptr_d     = '0;
            keys_ready_d = 1'b0;
            wr_err_d     = 1'b0;
            last_key_d   = '0;
            nr_d         = mode_nr;
        end else begin
            if (wr_en_i && keys_ready_q) begin
                wr_err_d = 1'b1;
            end
            if (wr_fire) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + AW'(1);
                if (wr_ptr_q == nr_q) begin
                    keys_ready_d = 1'b1;
                    last_key_d   = wr_data_i;
                end
            end
            if (rd_en_i) begin
                if (rd_hit_wr) begin
                    rd_data_d  = wr_data_i;
                    rd_valid_d = 1'b1;
                end else if (rd_hit_mem) begin
                    rd_data_d  = mem_q[rd_idx];
                    rd_valid_d = 1'b1;
                end else begin
                    rd_data_d = '0;
                    rd_miss_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            wr_ptr_q     <= '0;
            nr_q         <= Nr10;
            keys_ready_q <= 1'b0;
            wr_err_q     <= 1'b0;
            last_key_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_miss_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            wr_ptr_q     <= wr_ptr_d;
            nr_q         <= nr_d;
            keys_ready_q <= keys_ready_d;
            wr_err_q     <= wr_err_d;
            last_key_q   <= last_key_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_miss_q    <= rd_miss_d;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_miss_o    = rd_miss_q;
    assign wr_ptr_o     = wr_ptr_q;
    assign nr_o         = nr_q;
    assign keys_ready_o = keys_ready_q;
    assign wr_err_o     = wr_err_q;
    assign last_key_o   = last_key_q;

endmodule

// File: tb/tb_key_sched_store.sv
// Testbench for key_sched_store.
//
// Read responses are checked by a scoreboard. The stimulus pushes the expected
// response into a queue. The monitor pops one entry and compares it whenever the
// DUT pulses rd_valid_o or rd_miss_o. Status outputs are checked directly
// against constants.
module tb_key_sched_store;

    localparam int DW = 128;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_rev = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_miss;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] nr;
    logic          keys_ready;
    logic          wr_err;
    logic [DW-1:0] last_key;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic          miss;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    key_sched_store #(.DATA_W(DW), .NR_MAX(14), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr),
        .mode_i       (mode),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_rev_i     (rd_rev),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .rd_miss_o    (rd_miss),
        .wr_ptr_o     (wr_ptr),
        .nr_o         (nr),
        .keys_ready_o (keys_ready),
        .wr_err_o     (wr_err),
        .last_key_o   (last_key)
    );

    always #5 clk = ~clk;

    // Hand-readable key pattern: every 32-bit lane carries the key number
    function automatic logic [DW-1:0] key(input int i);
        return {32'(32'hA5C3_E100 + i), 32'(32'h5A3C_1E00 + i),
                32'(32'hDEAD_0000 + i), 32'(32'h0123_4500 + i)};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr(input logic [1:0] m);
        clr  = 1'b1;
        mode = m;
        tick();
        clr = 1'b0;
    endtask

    task automatic write_key(input int k);
        wr_en   = 1'b1;
        wr_data = key(k);
        tick();
        wr_en = 1'b0;
    endtask

    // Issue one read and queue its expected response. One negedge later the
    // monitor must have consumed that response.
    task automatic do_read(input logic [AW-1:0] a, input logic rev, input logic miss,
                           input logic [DW-1:0] data);
        rd_en   = 1'b1;
        rd_addr = a;
        rd_rev  = rev;
        exp_q.push_back('{miss: miss, data: data});
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        #1;
        check("rd_latency_pending", 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && (rd_valid || rd_miss)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got valid=%0b miss=%0b data=%h, required no response",
                         rd_valid, rd_miss, rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_valid !== ~e.miss || rd_miss !== e.miss || rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rd_resp: got valid=%0b miss=%0b data=%h, required valid=%0b miss=%0b data=%h",
                             rd_valid, rd_miss, rd_data, ~e.miss, e.miss, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset values
        #12;
        check("rst_rd_data", rd_data, 128'(0));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_rd_miss", 128'(rd_miss), 128'(0));
        check("rst_wr_ptr", 128'(wr_ptr), 128'(0));
        check("rst_nr", 128'(nr), 128'(10));
        check("rst_keys_ready", 128'(keys_ready), 128'(0));
        check("rst_wr_err", 128'(wr_err), 128'(0));
        check("rst_last_key", last_key, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 0: 11 keys; keys_ready rises right after K10
        do_clr(2'd0);
        check("a_nr", 128'(nr), 128'(10));
        for (int i = 0; i <= 10; i++) begin
            write_key(i);
            if (i == 9) check("a_ready_early", 128'(keys_ready), 128'(0));
        end
        check("a_keys_ready", 128'(keys_ready), 128'(1));
        check("a_wr_ptr", 128'(wr_ptr), 128'(11));
        check("a_last_key", last_key, key(10));
        do_read(4'd0, 1'b0, 1'b0, key(0));
        do_read(4'd0, 1'b1, 1'b0, key(10));
        do_read(4'd3, 1'b1, 1'b0, key(7));
        do_read(4'd11, 1'b0, 1'b1, 128'(0));
        do_read(4'd11, 1'b1, 1'b1, 128'(0));

        // A write after completion only sets the sticky error
        write_key(99);
        check("e_wr_err", 128'(wr_err), 128'(1));
        check("e_wr_ptr", 128'(wr_ptr), 128'(11));
        check("e_last_key", last_key, key(10));
        do_read(4'd10, 1'b0, 1'b0, key(10));
        check("e_wr_err_sticky", 128'(wr_err), 128'(1));

        // A mode change without clr leaves nr alone
        mode = 2'd2;
        tick();
        check("m_nr_hold", 128'(nr), 128'(10));

        // clr with a same-cycle write and read: both are dropped, no response
        clr     = 1'b1;
        mode    = 2'd0;
        wr_en   = 1'b1;
        wr_data = key(77);
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        rd_rev  = 1'b0;
        tick();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("c_wr_err", 128'(wr_err), 128'(0));
        check("c_keys_ready", 128'(keys_ready), 128'(0));
        check("c_wr_ptr", 128'(wr_ptr), 128'(0));
        check("c_last_key", last_key, 128'(0));
        @(negedge clk);
        #1;
        do_read(4'd0, 1'b0, 1'b1, 128'(0));

        // K0, K1, then K2 written while index 2 is read (write-first)
        write_key(16'h20);
        write_key(16'h21);
        wr_en   = 1'b1;
        wr_data = key(16'h22);
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        rd_rev  = 1'b0;
        exp_q.push_back('{miss: 1'b0, data: key(16'h22)});
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        #1;
        check("w_pending", 128'(exp_q.size()), 128'(0));
        check("w_wr_ptr", 128'(wr_ptr), 128'(3));
        do_read(4'd5, 1'b0, 1'b1, 128'(0));
        do_read(4'd1, 1'b0, 1'b0, key(16'h21));
        tick();
        check("h_rd_data_hold", rd_data, key(16'h21));
        check("h_rd_valid_low", 128'(rd_valid), 128'(0));

        // Mode 1: 13 keys; index 13 is out of range in both directions
        do_clr(2'd1);
        check("b_nr", 128'(nr), 128'(12));
        do_read(4'd13, 1'b0, 1'b1, 128'(0));
        for (int i = 0; i <= 12; i++) write_key(16'h40 + i);
        check("b_keys_ready", 128'(keys_ready), 128'(1));
        check("b_last_key", last_key, key(16'h4C));
        do_read(4'd13, 1'b0, 1'b1, 128'(0));
        do_read(4'd13, 1'b1, 1'b1, 128'(0));
        do_read(4'd0, 1'b1, 1'b0, key(16'h4C));

        // Mode 2: 15 keys, reverse read of index 3 gives K11
        do_clr(2'd2);
        check("d_nr", 128'(nr), 128'(14));
        for (int i = 0; i <= 14; i++) write_key(16'h80 + i);
        check("d_keys_ready", 128'(keys_ready), 128'(1));
        check("d_wr_ptr", 128'(wr_ptr), 128'(15));
        do_read(4'd3, 1'b1, 1'b0, key(16'h8B));
        do_read(4'd14, 1'b0, 1'b0, key(16'h8E));

        // Reserved mode 3 acts as 10 rounds
        do_clr(2'd3);
        check("r_nr", 128'(nr), 128'(10));

        // Mid-schedule reset takes effect at once
        do_clr(2'd1);
        for (int i = 0; i < 6; i++) write_key(16'hC0 + i);
        do_read(4'd5, 1'b0, 1'b0, key(16'hC5));
        rst_n = 1'b0;
        #1;
        check("x_rd_data", rd_data, 128'(0));
        check("x_wr_ptr", 128'(wr_ptr), 128'(0));
        check("x_nr", 128'(nr), 128'(10));
        check("x_keys_ready", 128'(keys_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        do_read(4'd0, 1'b0, 1'b1, 128'(0));
        check("x_nr_after", 128'(nr), 128'(10));

        tick();
        check("end_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/key_sched_store.md
KEY_SCHED_STORE -- requirements
Module: key_sched_store

Interface
REQ-001 Parameter DATA_W, default 128, SHALL be the round-key width in bits.
REQ-002 Parameter NR_MAX, default 14, SHALL be the maximum round count; depth is NR_MAX+1 entries.
REQ-003 Parameter AW, default 4, SHALL be the address/pointer width, where 2^AW >= NR_MAX+1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 clr  input  1  SHALL be a synchronous clear that starts a new key schedule.
REQ-007 mode  input  2  SHALL be the key-length select, sampled on clr: 0=10 rounds, 1=12, 2=14, 3=reserved (treated as 10).
REQ-008 wr_en  input  1  SHALL be the sequential key write strobe.
REQ-009 wr_data  input  DATA_W  SHALL be the key written at wr_ptr.
REQ-010 rd_en  input  1  SHALL be the read request.
REQ-011 rd_addr  input  AW  SHALL be the round index to read.
REQ-012 rd_rev  input  1  SHALL select reverse (decrypt) order: effective index = nr - rd_addr.
REQ-013 rd_data  output  DATA_W  SHALL be the registered read data.
REQ-014 rd_valid  output  1  SHALL qualify rd_data for one cycle.
REQ-015 rd_miss  output  1  SHALL pulse for one cycle when a read hits an unwritten or out-of-range index.
REQ-016 wr_ptr  output  AW  SHALL be the next write index.
REQ-017 nr  output  AW  SHALL be the latched round count (10/12/14).
REQ-018 keys_ready  output  1  SHALL be high when entries 0..nr are all written.
REQ-019 wr_err  output  1  SHALL be a sticky flag for writes attempted while keys_ready.
REQ-020 last_key  output  DATA_W  SHALL be registered entry nr, valid only while keys_ready.

Function
REQ-021 Storage SHALL be NR_MAX+1 x DATA_W, plus one valid bit per entry; storage contents are not reset.
REQ-022 wr_en with keys_ready=0 SHALL write mem[wr_ptr], set valid[wr_ptr], and increment wr_ptr.
REQ-023 The write that lands at index nr SHALL assert keys_ready on the next cycle; wr_ptr then holds at nr+1.
REQ-024 wr_en with keys_ready=1 SHALL leave memory and wr_ptr unchanged and set wr_err.
REQ-025 clr SHALL, in one cycle, zero all valid bits, wr_ptr, keys_ready and wr_err, and latch nr from mode.
REQ-026 clr SHALL take priority over wr_en and rd_en in the same cycle; a read in that cycle returns rd_valid=0 and rd_miss=0.
REQ-027 Read latency SHALL be 1 cycle: rd_en in cycle N produces rd_data, rd_valid or rd_miss in cycle N+1.
REQ-028 An effective index > nr, an index underflow under rd_rev, or an unset valid bit SHALL give rd_data=0, rd_valid=0, rd_miss=1.
REQ-029 A read and a write to the same effective index in the same cycle SHALL be write-first: rd_data=wr_data, rd_valid=1.
REQ-030 With rd_en low, rd_data SHALL hold its value and rd_valid/rd_miss SHALL be 0.
REQ-031 last_key SHALL update on the cycle keys_ready rises; it SHALL be 0 whenever keys_ready=0.
REQ-032 A mode change without clr SHALL have no effect on nr.

Reset
REQ-033 rst_n low SHALL immediately force rd_data=0, rd_valid=0, rd_miss=0, wr_ptr=0, nr=10, keys_ready=0, wr_err=0, last_key=0, and all valid bits to 0.
REQ-034 Reset asserted mid-schedule SHALL discard all progress; after release the block behaves as after clr with mode=0.

Verification
REQ-035 Reset, clr with mode=0, then 11 writes K0..K10 -> keys_ready=1 one cycle after K10; wr_ptr=11; last_key=K10.
REQ-036 clr with mode=2, then 15 writes; read rd_addr=3 with rd_rev=1 -> next cycle rd_data=K11, rd_valid=1.
REQ-037 mode=0 schedule complete, then wr_en -> wr_err=1, memory unchanged; then clr -> wr_err=0, keys_ready=0.
REQ-038 Three keys written; read index 5 -> rd_miss=1, rd_data=0; with mode=1, read index 13 -> rd_miss=1.
REQ-039 Write K2 and read index 2 in the same cycle -> next cycle rd_data=K2, rd_valid=1.
REQ-040 rst_n pulsed low after 6 writes -> outputs take their reset values immediately; a read of index 0 after release -> rd_miss=1.
